// File: rtl/weight_stream_loader.sv
// Streams a row-major weight image into a padded byte array, zero-filling pad
// columns. The array is read back as 8x8-byte tiles selected by (gp, level).
module weight_stream_loader #(
  parameter int ROWS  = 32,
  parameter int COLS  = 62,
  parameter int PCOLS = 64,
  parameter int GP_W  = 2,
  parameter int LV_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              done,
  output logic              loaded,
  input  logic              rd_en,
  input  logic [GP_W-1:0]   gp,
  input  logic [LV_W-1:0]   level,
  output logic [511:0]      out
);

  localparam int DEPTH = ROWS * PCOLS;
  localparam int AW    = $clog2(DEPTH);
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(PCOLS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] PAD  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]    state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [7:0]    mem [DEPTH];

  logic          wr_en;
  logic [7:0]    wr_data;
  logic [AW-1:0] wr_addr;
  logic          row_end;

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
  // in_ready is high only in LOAD and does not depend on in_valid.
  assign in_ready = (state == LOAD);

  always_comb begin
    wr_en   = 1'b0;
    wr_data = 8'h00;
    wr_addr = AW'(int'(row) * PCOLS + int'(col));
    if (state == LOAD && in_valid) begin
      wr_en   = 1'b1;
      wr_data = in_data;
    end else if (state == PAD) begin
      wr_en   = 1'b1;
    end
    row_end = wr_en && (col == CW'(PCOLS - 1));
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      row    <= '0;
      col    <= '0;
      done   <= 1'b0;
      loaded <= 1'b0;
    end else begin
      done <= 1'b0;
      if ((state == IDLE || state == DONE) && start) begin
        state  <= LOAD;
        row    <= '0;
        col    <= '0;
        loaded <= 1'b0;
      end else if (row_end) begin
        col <= '0;
        if (row == RW'(ROWS - 1)) begin
          state  <= DONE;
          done   <= 1'b1;
          loaded <= 1'b1;
        end else begin
          row   <= row + RW'(1);
          state <= LOAD;
        end
      end else if (wr_en) begin
        col <= col + CW'(1);
        // The last real column hands over to zero-fill for the remaining stride.
        if (state == LOAD && col == CW'(COLS - 1)) state <= PAD;
      end
    end
  end

  function automatic logic [AW-1:0] tile_addr(input logic [GP_W-1:0] g,
                                              input logic [LV_W-1:0] l,
                                              input int k);
    return AW'((int'(g) * 8 + k / 8) * PCOLS + int'(l) * 8 + k % 8);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= '0;
    end else if (rd_en && loaded) begin
      for (int k = 0; k < 64; k++) begin
        out[8*k +: 8] <= mem[tile_addr(gp, level, k)];
      end
    end
  end

endmodule

// File: tb/tb_weight_stream_loader.sv
// Directed bench for weight_stream_loader: a transaction-level model of the
// image and handshake is compared against the DUT outputs every cycle.
module tb_weight_stream_loader;

  localparam int ROWS  = 32;
  localparam int COLS  = 62;
  localparam int PCOLS = 64;
  localparam int GP_W  = 2;
  localparam int LV_W  = 3;

  logic              clk;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              done;
  logic              loaded;
  logic              rd_en;
  logic [GP_W-1:0]   gp;
  logic [LV_W-1:0]   level;
  logic [511:0]      out;

  weight_stream_loader #(
    .ROWS(ROWS), .COLS(COLS), .PCOLS(PCOLS), .GP_W(GP_W), .LV_W(LV_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .done(done), .loaded(loaded),
    .rd_en(rd_en), .gp(gp), .level(level), .out(out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [511:0] act,
                       input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model: accepted-byte count, pad gap, image, load status, read tile
  bit           m_active = 0;
  bit           m_loaded = 0;
  bit           m_done   = 0;
  int           m_n      = 0;
  int           m_gap    = 0;
  logic [511:0] m_out    = '0;
  logic [7:0]   m_img [ROWS*PCOLS];
  int           cyc      = 0;
  int           load_cyc = 0;
  int           done_cyc = 0;
  int           done_cnt = 0;

  function automatic logic [511:0] tile(input int g, input int l);
    logic [511:0] t;
    for (int k = 0; k < 64; k++) t[8*k +: 8] = m_img[(g*8 + k/8)*PCOLS + l*8 + k%8];
    return t;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_active = 0; m_loaded = 0; m_done = 0; m_n = 0; m_gap = 0; m_out = '0;
    end else begin
      m_done = 0;
      if (rd_en && m_loaded) m_out = tile(int'(gp), int'(level));
      if (m_active) begin
        if (m_gap > 0) begin
          m_gap--;
          if (m_gap == 0 && m_n == ROWS*COLS) begin
            m_active = 0; m_loaded = 1; m_done = 1;
          end
        end else if (in_valid) begin
          m_img[(m_n/COLS)*PCOLS + m_n%COLS] = in_data;
          m_n++;
          if (m_n % COLS == 0) begin
            for (int c = COLS; c < PCOLS; c++) m_img[((m_n-1)/COLS)*PCOLS + c] = 8'h00;
            m_gap = PCOLS - COLS;
            if (m_gap == 0 && m_n == ROWS*COLS) begin
              m_active = 0; m_loaded = 1; m_done = 1;
            end
          end
        end
      end else if (start) begin
        m_active = 1; m_n = 0; m_gap = 0; m_loaded = 0; load_cyc = cyc;
      end
    end
    #2;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    check("in_ready", in_ready, m_active && m_gap == 0);
    check("done", done, m_done);
    check("loaded", loaded, m_loaded);
    check("out", out, m_out);
  end

  // driver tasks
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic stream(input int nbytes, input int gap_pct, input int poke);
    int idx = 0;
    int guard = 0;
    bit acc;
    while (idx < nbytes && guard < 20000) begin
      in_valid = ($urandom_range(0, 99) >= gap_pct);
      in_data  = 8'(idx);
      start    = (idx == poke);
      acc      = in_valid && in_ready;
      @(negedge clk);
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check("stream_count", idx, nbytes);
  endtask

  task automatic finish_load(input int gap_pct, input int poke);
    int d0 = done_cnt;
    stream(ROWS*COLS, gap_pct, poke);
    repeat (4) @(negedge clk);
    check("done_once", done_cnt - d0, 1);
    check("loaded_after", loaded, 1'b1);
    if (gap_pct == 0) check("load_cycles", done_cyc - load_cyc, ROWS*PCOLS);
  endtask

  task automatic do_read(input int g, input int l);
    gp    = GP_W'(g);
    level = LV_W'(l);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic read_all();
    for (int g = 0; g < ROWS/8; g++)
      for (int l = 0; l < PCOLS/8; l++) do_read(g, l);
  endtask

  task automatic check_tile_1_7(input string tag);
    do_read(1, 7);
    check({tag, "_b0"}, out[7:0], 8'h28);
    check({tag, "_b5"}, out[47:40], 8'h2D);
    check({tag, "_b6"}, out[55:48], 8'h00);
    check({tag, "_b7"}, out[63:56], 8'h00);
    check({tag, "_b8"}, out[71:64], 8'h66);
    check({tag, "_model_b0"}, m_out[7:0], 8'h28);
    check({tag, "_model_b8"}, m_out[71:64], 8'h66);
  endtask

  logic [511:0] saved;

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    rd_en = 1'b0; gp = '0; level = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_out", out, '0);
    check("rst_loaded", loaded, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);

    // reads before any load are blocked
    do_read(1, 7);
    check("preload_out", out, '0);

    // full load without stalls; a start mid-load must be ignored
    do_start();
    finish_load(0, 500);
    check_tile_1_7("full");
    read_all();

    // start in DONE drops loaded; a read in that window holds out
    saved = out;
    do_start();
    check("loaded_drop", loaded, 1'b0);
    do_read(0, 0);
    check("out_hold", out, saved);

    // same image with random producer gaps
    finish_load(35, -1);
    check_tile_1_7("gaps");
    read_all();

    // reset after 100 bytes abandons the image
    do_start();
    stream(100, 20, -1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_loaded", loaded, 1'b0);
    check("midrst_out", out, '0);
    @(negedge clk);
    do_read(2, 3);
    check("midrst_read_blocked", out, '0);
    do_start();
    finish_load(10, -1);
    check_tile_1_7("reload");
    read_all();

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_stream_loader.md
WEIGHT_STREAM_LOADER -- requirements
Module: weight_stream_loader

Interface
REQ-001 SHALL have parameter ROWS, default 32: number of neuron rows stored.
REQ-002 SHALL have parameter COLS, default 62: number of weight bytes streamed per row.
REQ-003 SHALL have parameter PCOLS, default 64: padded row stride in bytes, with PCOLS >= COLS and PCOLS a multiple of 8.
REQ-004 SHALL have parameter GP_W, default 2: gp width, so that 8 * 2^GP_W = ROWS.
REQ-005 SHALL have parameter LV_W, default 3: level width, so that 8 * 2^LV_W = PCOLS.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port start, input, 1 bit: a one-cycle request to begin a new load.
REQ-009 SHALL have port in_valid, input, 1 bit: the producer has a weight byte on in_data.
REQ-010 SHALL have port in_data, input, 8 bits: the weight byte, streamed in row-major order.
REQ-011 SHALL have port in_ready, output, 1 bit: the loader accepts in_data this cycle.
REQ-012 SHALL have port done, output, 1 bit: a one-cycle pulse when the load completes.
REQ-013 SHALL have port loaded, output, 1 bit: the storage holds a complete, readable image.
REQ-014 SHALL have port rd_en, input, 1 bit: read request.
REQ-015 SHALL have port gp, input, GP_W bits: row group select, covering rows gp*8 .. gp*8+7.
REQ-016 SHALL have port level, input, LV_W bits: column group select, covering columns level*8 .. level*8+7.
REQ-017 SHALL have port out, output, 512 bits: the 64-byte read tile.

Function
REQ-018 SHALL hold a byte array of ROWS*PCOLS entries; row r, column c is located at address r*PCOLS+c.
REQ-019 SHALL implement an FSM with states IDLE, LOAD, PAD and DONE, plus a row counter (0..ROWS-1) and a column counter (0..PCOLS-1).
REQ-020 IDLE or DONE, start=1: SHALL go to LOAD and clear both counters and loaded at the next edge.
REQ-021 LOAD or PAD, start=1: SHALL ignore start.
REQ-022 SHALL drive in_ready=1 only in LOAD; a byte is accepted on a clock edge where in_valid && in_ready.
REQ-023 On an accepted byte: SHALL write in_data to address (row, col) and increment col.
REQ-024 On in_valid=0 in LOAD: SHALL leave state and counters unchanged.
REQ-025 When the byte at col=COLS-1 is accepted: SHALL go to PAD if COLS < PCOLS; otherwise SHALL perform the end-of-row step (REQ-027).
REQ-026 PAD: SHALL write 0x00 to (row, col) on each cycle and increment col; in_ready=0 throughout; PAD lasts PCOLS-COLS cycles per row.
REQ-027 End of row (col reaches PCOLS-1 written): col SHALL wrap to 0; if row < ROWS-1, row SHALL increment and state SHALL return to LOAD; if row = ROWS-1, state SHALL go to DONE.
REQ-028 On entry to DONE: SHALL assert done=1 for exactly one cycle and set loaded=1, both registered, in the cycle after the final write.
REQ-029 in_valid outside LOAD: SHALL be ignored with no write.
REQ-030 rd_en=1 && loaded=1: SHALL register out one cycle later, with byte k (out[8k+7:8k], k=0..63) = mem[(gp*8 + k/8)*PCOLS + level*8 + k%8].
REQ-031 rd_en=1 && loaded=0, or rd_en=0: out SHALL hold its previous value.
REQ-032 gp and level SHALL be sampled on the same edge as rd_en.
REQ-033 Reads and loading SHALL be independent paths; a start issued in DONE drops loaded, after which reads are blocked until the next DONE.
REQ-034 Total load time with no stalls SHALL be ROWS*PCOLS cycles from the first LOAD cycle to the final write.

Reset
REQ-035 rst=1, asynchronously: state SHALL be IDLE, counters 0, in_ready=0, done=0, loaded=0, out=0.
REQ-036 The storage array SHALL NOT be cleared by reset.
REQ-037 Reset mid-load SHALL abandon the partial image, which stays unreadable until a full load completes.
REQ-038 Deassertion of rst SHALL take effect at a clock edge with no spurious done pulse.

Verification
REQ-039 Full load, in_valid held at 1, byte(r,c) = (r*62+c) & 0xFF -> done pulses once, exactly 2048 cycles after LOAD entry; loaded=1.
REQ-040 After REQ-039, rd_en with gp=1, level=7 -> next cycle out byte0=0x28 (row 8, col 56), byte5=0x2D, byte6=0x00, byte7=0x00 (pad columns), byte8=0x66 (row 9, col 56).
REQ-041 Random in_valid gaps -> the same memory image as REQ-039; in_ready=0 for exactly 2 cycles after every 62nd accepted byte; no byte is lost or duplicated.
REQ-042 rst pulse after 100 accepted bytes -> in_ready=0, loaded=0, out=0; then start plus a full load -> a correct image starting at row 0.
REQ-043 rd_en before any load -> out stays 0; start pulsed during LOAD -> no restart, counters unaffected.
REQ-044 start in DONE -> loaded=0 on the next cycle; a rd_en in that window leaves out unchanged.
